// File: rtl/dispatch_ctrl_pkg.sv
// Shared encodings for the issue-stage dispatch controller: unit select, FSM states,
// and the per-unit space check.
package dispatch_ctrl_pkg;

  localparam int ROB_WIDTH_BIT = 4;

  typedef enum logic [1:0] {
    DISP_UNIT_RS   = 2'd0,
    DISP_UNIT_LSB  = 2'd1,
    DISP_UNIT_ROB  = 2'd2,
    DISP_UNIT_RSVD = 2'd3
  } disp_unit_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_JWAIT = 1'b1
  } disp_state_e;

  // A ROB entry is always needed; the target unit adds its own constraint.
  function automatic logic unit_space(input disp_unit_e unit,
                                      input logic       rob_full,
                                      input logic       rs_full,
                                      input logic       lsb_full);
    logic unit_ok;
    case (unit)
      DISP_UNIT_RS:  unit_ok = !rs_full;
      DISP_UNIT_LSB: unit_ok = !lsb_full;
      default:       unit_ok = 1'b1;
    endcase
    return !rob_full && unit_ok;
  endfunction

endpackage

// File: rtl/dispatch_ctrl_perf_counter.sv
// Free-running event counter: increments on inc, wraps modulo 2^CNT_W.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)   count <= '0;
    else if (inc) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// Issue-stage sequencer: one-entry skid register between decoder and ROB/RS/LSB,
// JALR serialisation through a RUN/JWAIT FSM, flush handling and perf counters.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int ROB_W = ROB_WIDTH_BIT,
  parameter int CNT_W = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [1:0]       dec_unit,
  input  logic             dec_is_jalr,
  input  logic             rob_full,
  input  logic [ROB_W-1:0] rob_free_id,
  input  logic             rs_full,
  input  logic             lsb_full,
  output logic             rob_valid,
  output logic             rs_valid,
  output logic             lsb_valid,
  output logic [ROB_W-1:0] disp_rob_id,
  input  logic             jalr_resolved,
  output logic             if_stall,
  output logic [CNT_W-1:0] perf_disp_cnt,
  output logic [CNT_W-1:0] perf_stall_cnt
);

  disp_state_e state, state_nxt;
  logic        hold_v, hold_v_nxt;
  disp_unit_e  hold_unit;
  logic        hold_jalr;

  logic live, run, space, fire, accept, stall_inc;

  // Reset is folded into live so the handshake is closed while rst_in is high.
  assign live      = rdy_in && !flush && !rst_in;
  assign run       = (state == ST_RUN);
  assign space     = unit_space(hold_unit, rob_full, rs_full, lsb_full);
  assign fire      = live && hold_v && run && space;
  assign stall_inc = live && hold_v && run && !space;
  assign dec_ready = live && run && (!hold_v || (fire && !hold_jalr));
  assign accept    = dec_valid && dec_ready;
  assign if_stall  = !dec_ready;

  assign rob_valid   = fire;
  assign rs_valid    = fire && (hold_unit == DISP_UNIT_RS);
  assign lsb_valid   = fire && (hold_unit == DISP_UNIT_LSB);
  assign disp_rob_id = fire ? rob_free_id : '0;

  // NOTE: defaults first, so every path assigns every output and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    hold_v_nxt = hold_v;
    if (rdy_in) begin
      if (flush) begin
        state_nxt  = ST_RUN;
        hold_v_nxt = 1'b0;
      end else if (fire && hold_jalr) begin
        state_nxt  = ST_JWAIT;
        hold_v_nxt = 1'b0;
      end else if (state == ST_JWAIT && jalr_resolved) begin
        state_nxt  = ST_RUN;
      end else begin
        hold_v_nxt = accept | (hold_v & !fire);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state  <= ST_RUN;
      hold_v <= 1'b0;
    end else begin
      state  <= state_nxt;
      hold_v <= hold_v_nxt;
    end
  end

  // Payload only moves on accept; accept is already gated by rdy_in and flush.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hold_unit <= DISP_UNIT_RS;
      hold_jalr <= 1'b0;
    end else if (accept) begin
      hold_unit <= disp_unit_e'(dec_unit);
      hold_jalr <= dec_is_jalr;
    end
  end

  perf_counter #(.CNT_W(CNT_W)) u_disp_cnt (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .inc    (fire),
    .count  (perf_disp_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .inc    (stall_inc),
    .count  (perf_stall_cnt)
  );

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: hand-computed expectations, immediate-assertion checks.
module tb_dispatch_ctrl;

  localparam int ROB_W = 4;
  localparam int CNT_W = 32;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             rdy_in;
  logic             flush;
  logic             dec_valid;
  logic             dec_ready;
  logic [1:0]       dec_unit;
  logic             dec_is_jalr;
  logic             rob_full;
  logic [ROB_W-1:0] rob_free_id;
  logic             rs_full;
  logic             lsb_full;
  logic             rob_valid;
  logic             rs_valid;
  logic             lsb_valid;
  logic [ROB_W-1:0] disp_rob_id;
  logic             jalr_resolved;
  logic             if_stall;
  logic [CNT_W-1:0] perf_disp_cnt;
  logic [CNT_W-1:0] perf_stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  dispatch_ctrl #(.ROB_W(ROB_W), .CNT_W(CNT_W)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .flush          (flush),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_unit       (dec_unit),
    .dec_is_jalr    (dec_is_jalr),
    .rob_full       (rob_full),
    .rob_free_id    (rob_free_id),
    .rs_full        (rs_full),
    .lsb_full       (lsb_full),
    .rob_valid      (rob_valid),
    .rs_valid       (rs_valid),
    .lsb_valid      (lsb_valid),
    .disp_rob_id    (disp_rob_id),
    .jalr_resolved  (jalr_resolved),
    .if_stall       (if_stall),
    .perf_disp_cnt  (perf_disp_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
    dec_valid = 1'b0; dec_unit = 2'd0; dec_is_jalr = 1'b0;
    rob_full = 1'b0; rob_free_id = '0; rs_full = 1'b0; lsb_full = 1'b0;
    jalr_resolved = 1'b0;

    // Held in reset: handshake closed, fetch stalled, counters zero.
    #2;
    check("rst_dec_ready", dec_ready, 0);
    check("rst_if_stall",  if_stall, 1);
    check("rst_rob_valid", rob_valid, 0);
    check("rst_disp_cnt",  perf_disp_cnt, 0);
    check("rst_stall_cnt", perf_stall_cnt, 0);
    tick(); tick();

    // Three RS instructions back-to-back.
    rst_in = 1'b0; dec_valid = 1'b1; dec_unit = 2'd0; rob_free_id = 4'd4; #1;
    check("b2b_ready0", dec_ready, 1);
    check("b2b_nofire0", rob_valid, 0);
    tick();
    rob_free_id = 4'd5; #1;
    check("b2b_rob1", rob_valid, 1);
    check("b2b_rs1",  rs_valid, 1);
    check("b2b_lsb1", lsb_valid, 0);
    check("b2b_id1",  disp_rob_id, 5);
    check("b2b_ready1", dec_ready, 1);
    tick();
    rob_free_id = 4'd6; #1;
    check("b2b_rs2", rs_valid, 1);
    check("b2b_id2", disp_rob_id, 6);
    tick();
    dec_valid = 1'b0; rob_free_id = 4'd7; #1;
    check("b2b_rs3", rs_valid, 1);
    check("b2b_id3", disp_rob_id, 7);
    tick();
    check("b2b_idle_rob", rob_valid, 0);
    check("b2b_idle_id",  disp_rob_id, 0);
    check("b2b_disp_cnt", perf_disp_cnt, 3);

    // LSB instruction blocked by lsb_full for four cycles.
    dec_valid = 1'b1; dec_unit = 2'd1; lsb_full = 1'b1; #1;
    check("lsb_accept", dec_ready, 1);
    tick();
    dec_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("lsb_blk_lsb", lsb_valid, 0);
      check("lsb_blk_rob", rob_valid, 0);
      check("lsb_blk_stall", if_stall, 1);
      tick();
    end
    lsb_full = 1'b0; #1;
    check("lsb_fire_rob", rob_valid, 1);
    check("lsb_fire_lsb", lsb_valid, 1);
    check("lsb_fire_rs",  rs_valid, 0);
    check("lsb_stall_cnt", perf_stall_cnt, 4);
    tick();
    check("lsb_disp_cnt", perf_disp_cnt, 4);

    // ROB full blocks an RS instruction even with RS space.
    dec_valid = 1'b1; dec_unit = 2'd0; rob_full = 1'b1;
    tick();
    dec_valid = 1'b0; #1;
    check("robfull_rob", rob_valid, 0);
    check("robfull_rs",  rs_valid, 0);
    tick();
    rob_full = 1'b0; #1;
    check("robfull_fire", rs_valid, 1);
    check("robfull_stall_cnt", perf_stall_cnt, 5);
    tick();

    // Reserved unit code dispatches as ROB-only, ignoring RS/LSB fullness.
    dec_valid = 1'b1; dec_unit = 2'd3; rs_full = 1'b1; lsb_full = 1'b1;
    tick();
    dec_valid = 1'b0; #1;
    check("rsvd_rob", rob_valid, 1);
    check("rsvd_rs",  rs_valid, 0);
    check("rsvd_lsb", lsb_valid, 0);
    tick();
    rs_full = 1'b0; lsb_full = 1'b0;
    check("rsvd_disp_cnt", perf_disp_cnt, 6);

    // JALR serialisation.
    dec_valid = 1'b1; dec_unit = 2'd2; dec_is_jalr = 1'b1;
    tick();
    dec_unit = 2'd0; dec_is_jalr = 1'b0; #1;
    check("jalr_fire", rob_valid, 1);
    check("jalr_fire_ready", dec_ready, 0);
    check("jalr_fire_stall", if_stall, 1);
    tick();
    check("jwait_stall0", if_stall, 1);
    check("jwait_rob0", rob_valid, 0);
    tick();
    check("jwait_stall1", if_stall, 1);
    jalr_resolved = 1'b1; #1;
    check("jwait_resolve_ready", dec_ready, 0);
    tick();
    jalr_resolved = 1'b0; #1;
    check("jrun_ready", dec_ready, 1);
    check("jrun_stall", if_stall, 0);
    tick();
    dec_valid = 1'b0; #1;
    check("jrun_fire", rs_valid, 1);
    tick();
    check("jalr_disp_cnt", perf_disp_cnt, 8);

    // Flush with a held instruction and a new one presented.
    dec_valid = 1'b1;
    tick();
    flush = 1'b1; #1;
    check("flush_nofire", rob_valid, 0);
    check("flush_noaccept", dec_ready, 0);
    tick();
    flush = 1'b0; dec_valid = 1'b0; #1;
    check("postflush_empty", rob_valid, 0);
    check("postflush_ready", dec_ready, 1);
    check("postflush_disp_cnt",  perf_disp_cnt, 8);
    check("postflush_stall_cnt", perf_stall_cnt, 5);

    // rdy_in low freezes everything.
    dec_valid = 1'b1;
    tick();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("frz_rob", rob_valid, 0);
      check("frz_ready", dec_ready, 0);
      tick();
    end
    check("frz_disp_cnt",  perf_disp_cnt, 8);
    check("frz_stall_cnt", perf_stall_cnt, 5);
    rdy_in = 1'b1; dec_valid = 1'b0; #1;
    check("unfrz_fire", rob_valid, 1);
    tick();
    check("unfrz_disp_cnt", perf_disp_cnt, 9);

    // Reset mid-run with a fire-ready instruction held.
    dec_valid = 1'b1;
    tick();
    dec_valid = 1'b0; #1;
    check("prerst_fire", rob_valid, 1);
    rst_in = 1'b1; #1;
    check("midrst_rob", rob_valid, 0);
    check("midrst_rs",  rs_valid, 0);
    check("midrst_ready", dec_ready, 0);
    check("midrst_if_stall", if_stall, 1);
    check("midrst_disp_cnt",  perf_disp_cnt, 0);
    check("midrst_stall_cnt", perf_stall_cnt, 0);
    tick();
    rst_in = 1'b0; #1;
    check("postrst_empty", rob_valid, 0);
    check("postrst_ready", dec_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
